// File: rtl/fifo_flags.sv
// Synchronous FIFO with occupancy count and full/almost_full/empty/almost_empty flags.
// Define FIFO_ERROR_STICKY_EN to make overflow/underflow hold until reset.
module fifo_flags #(
    parameter int DATA_WIDTH      = 6,
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_TH   = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_TH   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push_ok, pop_ok, push_rej, pop_rej;

    // Flags decode the count register only, so they never depend on this cycle's inputs.
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_TH);
    assign empty        = (count_q == '0);
    assign almost_empty = (count_q <= AE_TH);

    // A pop frees a slot in the same edge, so a full FIFO may still take a push alongside it.
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;
    assign push_rej = push && full && !pop;
    assign pop_rej  = pop && empty;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves a signal unassigned (no latches).
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = pop_ok;

        if (push_ok) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok) begin
            data_out_d = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
        end

        if (push_ok && !pop_ok) begin
            count_d = count_q + (ADDR_WIDTH+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (ADDR_WIDTH+1)'(1);
        end

`ifdef FIFO_ERROR_STICKY_EN
        overflow_d  = overflow_q  || push_rej;
        underflow_d = underflow_q || pop_rej;
`else
        overflow_d  = push_rej;
        underflow_d = pop_rej;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags: popped data goes through a scoreboard queue, status is checked per cycle.
module tb_fifo_flags;

    localparam int DW = 6;
    localparam int AW = 3;
`ifdef FIFO_ERROR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, push, pop;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [AW:0]   count;
    logic          full, almost_full, empty, almost_empty, overflow, underflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q [$];

    fifo_flags dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .count        (count),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input int c);
        check({tag, " count"}, 32'(count), 32'(c));
        check({tag, " empty"}, 32'(empty), 32'(c == 0));
        check({tag, " almost_empty"}, 32'(almost_empty), 32'(c <= 2));
        check({tag, " almost_full"}, 32'(almost_full), 32'(c >= 6));
        check({tag, " full"}, 32'(full), 32'(c == 8));
    endtask

    // Monitor: every valid_out cycle must match the oldest expected word.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got valid data %0h with nothing expected", data_out);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    n_err++;
                    $display("FAIL sb_data: got %0h expected %0h (t=%0t)", data_out, e, $time);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; push = 1'b1; pop = 1'b0; data_in = 6'h3F;
        step(); step();
        check_flags("rst", 0);
        check("rst valid_out", 32'(valid_out), 0);
        check("rst data_out", 32'(data_out), 0);
        check("rst overflow", 32'(overflow), 0);
        check("rst underflow", 32'(underflow), 0);

        // Fill 1..8, flag transitions checked after every push
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; data_in = DW'(i);
            step();
            check_flags($sformatf("fill%0d", i), i);
        end
        data_in = 6'h09;
        step();
        check("ovf overflow", 32'(overflow), 1);
        check("ovf count", 32'(count), 8);
        push = 1'b0;

        // Drain: 01..08 in order
        for (int i = 1; i <= 8; i++) begin
            pop = 1'b1;
            exp_q.push_back(DW'(i));
            step();
            check_flags($sformatf("drain%0d", i), 8 - i);
            check("drain valid_out", 32'(valid_out), 1);
            check("drain overflow", 32'(overflow), 32'(STICKY));
        end
        pop = 1'b0; push = 1'b1; data_in = 6'h2A;
        step();
        check("wrap count", 32'(count), 1);
        push = 1'b0; pop = 1'b1;
        exp_q.push_back(6'h2A);
        step();
        check("wrap count after pop", 32'(count), 0);
        check("wrap valid_out", 32'(valid_out), 1);
        pop = 1'b0;

        // Refill, then simultaneous push/pop while full
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; data_in = DW'(6'h10 + i);
            step();
        end
        check_flags("refill", 8);
        push = 1'b1; pop = 1'b1; data_in = 6'h15;
        exp_q.push_back(6'h10);
        step();
        check("fullpp count", 32'(count), 8);
        check("fullpp overflow", 32'(overflow), 32'(STICKY));
        check("fullpp valid_out", 32'(valid_out), 1);
        push = 1'b0; pop = 1'b0;

        reset = 1'b1;
        step();
        reset = 1'b0;
        check_flags("rst2", 0);
        check("rst2 overflow", 32'(overflow), 0);

        // Simultaneous push/pop while empty
        push = 1'b1; pop = 1'b1; data_in = 6'h07;
        step();
        check("emptypp count", 32'(count), 1);
        check("emptypp underflow", 32'(underflow), 1);
        check("emptypp valid_out", 32'(valid_out), 0);
        push = 1'b0;
        exp_q.push_back(6'h07);
        step();
        check("pop7 count", 32'(count), 0);
        check("pop7 underflow", 32'(underflow), 32'(STICKY));

        // Underflow then 5 cycles of normal traffic
        step();
        check("uf underflow", 32'(underflow), 1);
        check("uf valid_out", 32'(valid_out), 0);
        for (int k = 0; k < 5; k++) begin
            push = (k % 2 == 0);
            pop  = (k % 2 == 1);
            data_in = DW'(6'h30 + k);
            if (pop) exp_q.push_back(DW'(6'h30 + k - 1));
            step();
            check($sformatf("traffic%0d underflow", k), 32'(underflow), 32'(STICKY));
            check($sformatf("traffic%0d count", k), 32'(count), 32'(k % 2 == 0));
        end
        push = 1'b0; pop = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst3 underflow", 32'(underflow), 0);

        // Mid-operation reset together with pop
        for (int i = 1; i <= 5; i++) begin
            push = 1'b1; data_in = DW'(6'h20 + i);
            step();
        end
        check("mid count", 32'(count), 5);
        push = 1'b0; pop = 1'b1; reset = 1'b1;
        step();
        check_flags("midrst", 0);
        check("midrst valid_out", 32'(valid_out), 0);
        check("midrst data_out", 32'(data_out), 0);
        pop = 1'b0; reset = 1'b0;
        step(); step();

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_flags.md
# fifo_flags

Synchronous FIFO that stores data words and generates the `full`, `almost_full`, `empty` and `almost_empty` status flags consumed by the flow-control state machine (`fsm`). It is the flag-producing end of the flow-control interface. The `fsm` reads these flags and returns `pausa`/`continuar`. Upstream logic gates `push` with `continuar`, and downstream logic issues `pop`.

## Interface
Parameters:
- `DATA_WIDTH`, 6, width of a stored word
- `ADDR_WIDTH`, 3, log2 of depth; depth = 2^ADDR_WIDTH (8)
- `ALMOST_FULL_TH`, 6, `almost_full` asserts when count >= this value
- `ALMOST_EMPTY_TH`, 2, `almost_empty` asserts when count <= this value

Ports:
- `clk`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `push`  in  1  write request; `data_in` is captured on the same edge
- `data_in`  in  DATA_WIDTH  write data
- `pop`  in  1  read request
- `data_out`  out  DATA_WIDTH  registered read data
- `valid_out`  out  1  `data_out` holds a newly popped word this cycle
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..depth
- `full`  out  1  count == depth
- `almost_full`  out  1  count >= ALMOST_FULL_TH (also high when full)
- `empty`  out  1  count == 0
- `almost_empty`  out  1  count <= ALMOST_EMPTY_TH (also high when empty)
- `overflow`  out  1  a push was rejected
- `underflow`  out  1  a pop was rejected

## Operation
- Storage: register array of depth entries. Write pointer and read pointer are ADDR_WIDTH bits and wrap modulo depth. `count` is held in a separate ADDR_WIDTH+1 bit register.
- Accepted push: `push` && (!`full` || `pop`). Writes `mem[wr_ptr]` and advances `wr_ptr`.
- Accepted pop: `pop` && !`empty`. Loads `data_out` from `mem[rd_ptr]`, sets `valid_out`=1 and advances `rd_ptr`.
- `count` update: +1 on push only, -1 on pop only, unchanged when both or neither are accepted.
- Push and pop while full: both are accepted, `count` stays at depth, no overflow.
- Push and pop while empty: the push is accepted and the pop is rejected. `count` becomes 1 and `underflow` asserts.
- Rejected push (`push` && `full` && !`pop`): data is dropped, state is unchanged, `overflow` asserts.
- Rejected pop (`pop` && `empty`): `data_out` holds its value, `valid_out`=0, `underflow` asserts.
- Flags are combinational decodes of the `count` register only. They carry no input-to-output combinational path.
- There is no internal FSM. Occupancy states are EMPTY, LOW (almost_empty), MID, HIGH (almost_full) and FULL, all implied by `count`.

## Timing
- Reset values: `count`=0, pointers=0, `data_out`=0, `valid_out`=0, `overflow`=0, `underflow`=0, `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0. Memory contents are not reset.
- `reset` takes priority over `push`/`pop` in the same cycle. A reset mid-operation discards all contents in one edge.
- Push latency: a word pushed at edge N is poppable at edge N+1. Flags reflect the new count after edge N.
- Pop latency: `data_out` and `valid_out` are valid in the cycle after the popping edge. `valid_out` lasts one cycle per accepted pop.
- Back-to-back push or pop every cycle is sustained at full throughput.
- Without the sticky option, `overflow` and `underflow` are high for exactly the one cycle following the offending edge.

## Configuration
- `FIFO_ERROR_STICKY_EN` defined: `overflow` and `underflow` latch at 1 after the first rejected request and clear only on `reset`. This matches the `fsm` error-hold behaviour.
- Not defined: `overflow` and `underflow` are single-cycle pulses as described under Timing.

## Test plan
- Reset check: hold `reset`=1 for 2 cycles with `push`=1 -> `count`=0, `empty`=1, `almost_empty`=1, all other outputs 0.
- Fill sequence: push 0x01..0x08 on consecutive cycles.
  - `almost_empty` drops after the 3rd push.
  - `almost_full` rises after the 6th push.
  - `full` rises after the 8th push, with `count`=8.
  - A 9th push -> `overflow` asserts and `count` stays 8.
- Drain and wrap-around: pop 8 times -> `data_out` = 0x01..0x08 in order with `valid_out`=1 each cycle, ending `empty`=1. Then push 0x2A and pop once -> `data_out`=0x2A after the pointers wrap.
- Simultaneous push and pop:
  - When full: push 0x15 and pop together -> `count` stays 8, no `overflow`, the oldest word is output.
  - When empty: push and pop together -> `count`=1, `underflow`=1, `valid_out`=0.
- Sticky errors: pop while empty, then issue normal traffic for 5 cycles.
  - Without `FIFO_ERROR_STICKY_EN`: `underflow` is high for 1 cycle only.
  - With `FIFO_ERROR_STICKY_EN`: `underflow` stays 1 until `reset` is pulsed.
- Mid-operation reset: push 5 words, assert `reset` together with `pop` -> next cycle `count`=0, `valid_out`=0, `data_out`=0.
